mem_arbiter: RTL and testbench

- N-channel memory front-end arbiter; generalises the current two-port stim/check memory mux to N_CH requestors.
- Each requestor may issue reads or writes; reads may be pipelined with up to MAX_OUTSTANDING in flight.
- Read data is routed back to the issuing channel via an in-order tag FIFO.
- Sits between the test engines (stim, check, future loggers) and the single external SRAM port.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_tag_fifo.sv | 60 ++++++
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-channel memory arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_RR     = 0;
    localparam int unsigned ARB_FIXED  = 1;
    localparam int unsigned STAT_WIDTH = 16;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO recording which channel owns each outstanding read.
module mem_arb_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = store[rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel front-end arbiter onto a single SRAM port with in-order read-return routing.
// Optional per-channel grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 20,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned N_CH            = 4,
    parameter int unsigned CH_WIDTH        = $clog2(N_CH),
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned ARB_MODE        = ARB_RR
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_CH*ADDR_WIDTH-1:0] ch_address,
    input  logic [N_CH*BE_WIDTH-1:0]   ch_byteenable,
    input  logic [N_CH-1:0]            ch_read,
    input  logic [N_CH-1:0]            ch_write,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_writedata,
    output logic [N_CH-1:0]            ch_waitrequest,
    output logic [DATA_WIDTH-1:0]      ch_readdata,
    output logic [N_CH-1:0]            ch_readdataready,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic [BE_WIDTH-1:0]        mem_byteenable,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [DATA_WIDTH-1:0]      mem_writedata,
    input  logic [DATA_WIDTH-1:0]      mem_readdata,
    input  logic                       mem_readdataready,
    input  logic                       mem_waitrequest,
    output logic                       idle,
    output logic                       err,
    input  logic [CH_WIDTH-1:0]        stat_sel,
    output logic [STAT_WIDTH-1:0]      stat_count
);

    localparam int unsigned LVL_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e          state;
    logic [CH_WIDTH-1:0] grant;
    logic [CH_WIDTH-1:0] rr_ptr;
    logic                err_q;

    logic [ADDR_WIDTH-1:0] addr_arr [N_CH];
    logic [BE_WIDTH-1:0]   be_arr   [N_CH];
    logic [DATA_WIDTH-1:0] wdata_arr[N_CH];

    logic [N_CH-1:0]     eligible;
    logic                any_elig;
    logic [CH_WIDTH-1:0] winner;

    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;
    logic [CH_WIDTH-1:0] fifo_tag;
    logic                fifo_push;
    logic                fifo_pop;

    logic in_grant;
    logic g_rd;
    logic g_wr;
    logic g_cmd;
    logic accept;
    logic dropped;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            addr_arr[i]  = ch_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            be_arr[i]    = ch_byteenable[i*BE_WIDTH +: BE_WIDTH];
            wdata_arr[i] = ch_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Registered FIFO occupancy gates reads; a same-cycle pop does not free a slot early.
    assign eligible = ch_write | (ch_read & {N_CH{!fifo_full}});

    always_comb begin
        winner   = '0;
        any_elig = 1'b0;
        // Scan from the far end so the closest eligible index wins last.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ARB_MODE == ARB_FIXED) begin
                if (eligible[CH_WIDTH'(k)]) begin
                    winner   = CH_WIDTH'(k);
                    any_elig = 1'b1;
                end
            end else begin
                if (eligible[CH_WIDTH'((int'(rr_ptr) + k) % N_CH)]) begin
                    winner   = CH_WIDTH'((int'(rr_ptr) + k) % N_CH);
                    any_elig = 1'b1;
                end
            end
        end
    end

    assign in_grant = (state == S_GRANT);
    assign g_rd     = ch_read[grant];
    assign g_wr     = ch_write[grant];
    // Read+write together is issued as a write; a lone read never pushes into a full FIFO.
    assign g_cmd    = in_grant && (g_wr || (g_rd && !fifo_full));
    assign accept   = g_cmd && !mem_waitrequest;
    assign dropped  = in_grant && !g_wr && !g_rd;

    assign fifo_push = accept && !g_wr;
    assign fifo_pop  = mem_readdataready && !fifo_empty;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ch_waitrequest = '1;
        if (in_grant) begin
            mem_address           = addr_arr[grant];
            mem_byteenable        = be_arr[grant];
            mem_writedata         = wdata_arr[grant];
            mem_write             = g_wr;
            mem_read              = g_rd && !g_wr && !fifo_full;
            ch_waitrequest[grant] = mem_waitrequest || !g_cmd;
        end
    end

    always_comb begin
        ch_readdataready = '0;
        if (fifo_pop) begin
            ch_readdataready[fifo_tag] = 1'b1;
        end
    end

    assign ch_readdata = mem_readdata;
    assign idle        = (state == S_IDLE) && (fifo_level == '0);
    assign err         = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (mem_readdataready && fifo_empty) begin
                err_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (any_elig) begin
                        grant <= winner;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (g_wr && g_rd) begin
                        err_q <= 1'b1;
                    end
                    if (dropped) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else if (accept) begin
                        rr_ptr <= (grant == CH_WIDTH'(N_CH - 1)) ? '0 : grant + 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mem_arb_tag_fifo #(
        .WIDTH (CH_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (grant),
        .pop       (fifo_pop),
        .pop_data  (fifo_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_cnt [N_CH];
    logic [STAT_WIDTH-1:0] stat_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                stat_cnt[i] <= '0;
            end
            stat_q <= '0;
        end else begin
            if (accept && (stat_cnt[grant] != '1)) begin
                stat_cnt[grant] <= stat_cnt[grant] + 1'b1;
            end
            stat_q <= (32'(stat_sel) < N_CH) ? stat_cnt[stat_sel] : '0;
        end
    end

    assign stat_count = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: round-robin instance plus a fixed-priority instance.
module tb_mem_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int BW  = 2;

    typedef struct packed {
        logic          wr;
        logic [NCH-1:0] oh;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [NCH-1:0] oh;
        logic [DW-1:0]  data;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [NCH*AW-1:0] ch_address    = '0;
    logic [NCH*BW-1:0] ch_byteenable = 8'b01_10_11_01;
    logic [NCH-1:0]    ch_read       = '0;
    logic [NCH-1:0]    ch_write      = '0;
    logic [NCH*DW-1:0] ch_writedata  = '0;
    logic [NCH-1:0]    ch_waitrequest;
    logic [DW-1:0]     ch_readdata;
    logic [NCH-1:0]    ch_readdataready;
    logic [AW-1:0]     mem_address;
    logic [BW-1:0]     mem_byteenable;
    logic              mem_read;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic [DW-1:0]     mem_readdata      = '0;
    logic              mem_readdataready = 1'b0;
    logic              mem_waitrequest   = 1'b0;
    logic              idle;
    logic              err;
    logic [1:0]        stat_sel = 2'd3;
    logic [15:0]       stat_count;

    logic [NCH*AW-1:0] b_ch_address = '0;
    logic [NCH-1:0]    b_ch_write   = '0;
    logic [NCH-1:0]    b_ch_waitrequest;
    logic [DW-1:0]     b_ch_readdata;
    logic [NCH-1:0]    b_ch_readdataready;
    logic [AW-1:0]     b_mem_address;
    logic [BW-1:0]     b_mem_byteenable;
    logic              b_mem_read;
    logic              b_mem_write;
    logic [DW-1:0]     b_mem_writedata;
    logic              b_idle;
    logic              b_err;
    logic [15:0]       b_stat_count;

    mem_arbiter #(.ARB_MODE(0)) dut (
        .clock             (clock),
        .reset             (reset),
        .ch_address        (ch_address),
        .ch_byteenable     (ch_byteenable),
        .ch_read           (ch_read),
        .ch_write          (ch_write),
        .ch_writedata      (ch_writedata),
        .ch_waitrequest    (ch_waitrequest),
        .ch_readdata       (ch_readdata),
        .ch_readdataready  (ch_readdataready),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata),
        .mem_readdataready (mem_readdataready),
        .mem_waitrequest   (mem_waitrequest),
        .idle              (idle),
        .err               (err),
        .stat_sel          (stat_sel),
        .stat_count        (stat_count)
    );

    mem_arbiter #(.ARB_MODE(1)) dut_fixed (
        .clock             (clock),
        .reset             (reset),
        .ch_address        (b_ch_address),
        .ch_byteenable     (ch_byteenable),
        .ch_read           (4'b0000),
        .ch_write          (b_ch_write),
        .ch_writedata      (ch_writedata),
        .ch_waitrequest    (b_ch_waitrequest),
        .ch_readdata       (b_ch_readdata),
        .ch_readdataready  (b_ch_readdataready),
        .mem_address       (b_mem_address),
        .mem_byteenable    (b_mem_byteenable),
        .mem_read          (b_mem_read),
        .mem_write         (b_mem_write),
        .mem_writedata     (b_mem_writedata),
        .mem_readdata      (16'h0000),
        .mem_readdataready (1'b0),
        .mem_waitrequest   (1'b0),
        .idle              (b_idle),
        .err               (b_err),
        .stat_sel          (2'd3),
        .stat_count        (b_stat_count)
    );

    always #5 clock = ~clock;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   b_acc0 = 0;
    int   b_acc3 = 0;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   acc_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every accepted memory command and every read return is matched in order.
    always @(negedge clock) begin
        if (!reset) begin
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                cmd_t act;
                act.wr   = mem_write;
                act.oh   = ~ch_waitrequest;
                act.addr = mem_address;
                act.be   = mem_byteenable;
                act.data = mem_write ? mem_writedata : '0;
                acc_cyc.push_back(cyc);
                if (cmd_q.size() == 0) check("unexpected_cmd", 64'(act), 64'd0);
                else check("cmd", 64'(act), 64'(cmd_q.pop_front()));
            end
            if (|ch_readdataready) begin
                rsp_t ra;
                ra.oh   = ch_readdataready;
                ra.data = ch_readdata;
                if (rsp_q.size() == 0) check("unexpected_rsp", 64'(ra), 64'd0);
                else check("rsp", 64'(ra), 64'(rsp_q.pop_front()));
            end
            if (b_mem_write) begin
                if (!b_ch_waitrequest[0]) b_acc0++;
                if (!b_ch_waitrequest[3]) b_acc3++;
            end
        end
    end

    function automatic logic [BW-1:0] be_of(input int ch);
        logic [NCH*BW-1:0] tab;
        tab = 8'b01_10_11_01;
        return tab[ch*BW +: BW];
    endfunction

    function automatic cmd_t mk_cmd(input int ch, input bit wr, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d);
        cmd_t c;
        c.wr   = wr;
        c.oh   = NCH'(1) << ch;
        c.addr = a;
        c.be   = be_of(ch);
        c.data = wr ? d : '0;
        return c;
    endfunction

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Waits for the channel's stall to drop; holds mem_waitrequest for the first stall cycles.
    task automatic wait_accept(input int ch, input int stall, output int lat);
        bit done = 1'b0;
        lat = 0;
        while (!done && lat < 24) begin
            @(negedge clock);
            lat++;
            if (!ch_waitrequest[ch]) done = 1'b1;
            @(posedge clock); #1;
            if (lat >= stall) mem_waitrequest = 1'b0;
        end
        if (!done) check("accept_timeout", 64'(ch), 64'hFFFF);
        mem_waitrequest = 1'b0;
    endtask

    task automatic do_cmd(input int ch, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int stall, output int lat);
        ch_address[ch*AW +: AW]   = a;
        ch_writedata[ch*DW +: DW] = d;
        ch_read[ch]               = !wr;
        ch_write[ch]              = wr;
        mem_waitrequest           = (stall > 0);
        cmd_q.push_back(mk_cmd(ch, wr, a, d));
        wait_accept(ch, stall, lat);
        ch_read[ch]  = 1'b0;
        ch_write[ch] = 1'b0;
    endtask

    task automatic ret(input logic [NCH-1:0] oh, input logic [DW-1:0] d);
        rsp_t r;
        r.oh = oh;
        r.data = d;
        rsp_q.push_back(r);
        mem_readdata      = d;
        mem_readdataready = 1'b1;
        @(posedge clock); #1;
        mem_readdataready = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_waitreq", 64'(ch_waitrequest), 64'hF);
        check("rst_rdready", 64'(ch_readdataready), 64'h0);
        check("rst_mem_strobe", 64'({mem_read, mem_write}), 64'h0);
        check("rst_mem_bus", 64'({mem_address, mem_byteenable, mem_writedata}), 64'h0);
        check("rst_err_idle", 64'({err, idle}), 64'h1);
        check("rst_stat", 64'(stat_count), 64'h0);
        @(posedge clock); #1;

        // Single read on ch1, data returned a few cycles later
        do_cmd(1, 1'b0, 20'h00010, 16'h0, 0, lat);
        check("read_latency", 64'(lat), 64'd2);
        repeat (2) @(posedge clock);
        #1 ret(4'b0010, 16'hBEEF);

        // Round robin: ch0 and ch2 hold writes continuously
        do_reset();
        acc_cyc.delete();
        ch_address[0*AW +: AW]   = 20'h00200;
        ch_address[2*AW +: AW]   = 20'h00202;
        ch_writedata[0*DW +: DW] = 16'hA000;
        ch_writedata[2*DW +: DW] = 16'hA002;
        cmd_q.push_back(mk_cmd(0, 1'b1, 20'h00200, 16'hA000));
        cmd_q.push_back(mk_cmd(2, 1'b1, 20'h00202, 16'hA002));
        cmd_q.push_back(mk_cmd(0, 1'b1, 20'h00200, 16'hA000));
        cmd_q.push_back(mk_cmd(2, 1'b1, 20'h00202, 16'hA002));
        ch_write = 4'b0101;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock); #1;
            if (acc_cyc.size() >= 4) break;
        end
        @(posedge clock); #1;
        ch_write = 4'b0000;
        check("rr_count", 64'(acc_cyc.size()), 64'd4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            check("rr_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);

        // Write on ch3 with memory stalling the first granted cycle
        do_cmd(3, 1'b1, 20'h00333, 16'h1234, 2, lat);
        check("stall_latency", 64'(lat), 64'd3);
        check("no_err_yet", 64'(err), 64'd0);

        // Outstanding limit: 8 reads fill the tag FIFO
        do_reset();
        for (int i = 0; i < 8; i++) do_cmd(0, 1'b0, 20'h00100 + 20'(i), 16'h0, 0, lat);
        ch_address[1*AW +: AW]   = 20'h00111;
        ch_address[2*AW +: AW]   = 20'h00222;
        ch_writedata[2*DW +: DW] = 16'h5A5A;
        cmd_q.push_back(mk_cmd(2, 1'b1, 20'h00222, 16'h5A5A));
        ch_read[1]  = 1'b1;
        ch_write[2] = 1'b1;
        wait_accept(2, 0, lat);
        ch_write[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("full_read_stalled", 64'({ch_waitrequest[1], mem_read}), 64'h2);
        end
        @(posedge clock); #1;
        cmd_q.push_back(mk_cmd(1, 1'b0, 20'h00111, 16'h0));
        ret(4'b0001, 16'hD000);
        wait_accept(1, 0, lat);
        ch_read[1] = 1'b0;
        for (int i = 1; i < 8; i++) ret(4'b0001, 16'hD000 + 16'(i));
        ret(4'b0010, 16'hD008);
        @(negedge clock);
        check("drained_idle", 64'({idle, err}), 64'h2);

        // Unexpected read data with an empty tag FIFO
        @(posedge clock); #1;
        mem_readdata      = 16'hDEAD;
        mem_readdataready = 1'b1;
        @(negedge clock);
        check("stray_rdready", 64'(ch_readdataready), 64'h0);
        check("stray_err_pre", 64'(err), 64'd0);
        @(posedge clock); #1;
        mem_readdataready = 1'b0;
        @(negedge clock);
        check("stray_err", 64'(err), 64'd1);

        // Reset mid-operation with three reads outstanding
        do_reset();
        for (int i = 0; i < 3; i++) do_cmd(3, 1'b0, 20'h00400 + 20'(i), 16'h0, 0, lat);
        check("busy_idle", 64'(idle), 64'd0);
        reset = 1'b1;
        #1;
        check("midrst_state", 64'({idle, err, ch_waitrequest}), 64'h2F);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("postrst_state", 64'({idle, err, ch_waitrequest}), 64'h2F);
        @(posedge clock); #1;
        mem_readdataready = 1'b1;
        @(negedge clock);
        check("late_rdready", 64'(ch_readdataready), 64'h0);
        @(posedge clock); #1;
        mem_readdataready = 1'b0;
        @(negedge clock);
        check("late_err", 64'(err), 64'd1);

        // Fixed priority instance: ch0 always wins over ch3
        @(posedge clock); #1;
        b_ch_write = 4'b1001;
        repeat (12) @(negedge clock);
        @(posedge clock); #1;
        b_ch_write = 4'b0000;
        @(negedge clock);
        check("fixed_ch0", 64'(b_acc0), 64'd6);
        check("fixed_ch3", 64'(b_acc3), 64'd0);
        check("fixed_stat3", 64'(b_stat_count), 64'd0);
        check("fixed_err", 64'(b_err), 64'd0);

        check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
